// File: rtl/data_mem_responder_pkg.sv
// data_mem_responder shared definitions:
// access size codes, FSM states, wait counter width.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACCESS,
    RESP
  } state_t;

endpackage

// File: rtl/data_mem_responder_if.sv
// Load/store request and response channels
// between the core (master) and data memory (slave).
interface data_mem_responder_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_error;

  modport master (
    output req_valid, req_write, req_addr,
    output req_wdata, req_size, req_unsigned,
    output rsp_ready,
    input  req_ready, rsp_valid,
    input  rsp_rdata, rsp_error
  );

  modport slave (
    input  req_valid, req_write, req_addr,
    input  req_wdata, req_size, req_unsigned,
    input  rsp_ready,
    output req_ready, rsp_valid,
    output rsp_rdata, rsp_error
  );

endinterface

// File: rtl/data_mem_responder_lane_align.sv
// Little-endian byte-lane steering: store merge
// into an old word and load extract with extension.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic [1:0]  offs,
  input  logic        isUnsigned,
  output logic [31:0] newWord,
  output logic [31:0] loadData
);

  logic [7:0]  bSel;
  logic [15:0] hSel;

  always_comb begin
    newWord  = word;
    loadData = word;
    bSel     = word[{offs, 3'b000} +: 8];
    hSel     = offs[1] ? word[31:16] : word[15:0];
    unique case (size)
      SZ_BYTE: begin
        newWord[{offs, 3'b000} +: 8] = wdata[7:0];
        loadData = {{24{!isUnsigned && bSel[7]}}, bSel};
      end
      SZ_HALF: begin
        if (offs[1]) newWord[31:16] = wdata[15:0];
        else         newWord[15:0]  = wdata[15:0];
        loadData = {{16{!isUnsigned && hSel[15]}}, hSel};
      end
      default: newWord = wdata;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Load/store responder with wait states over a word array.
// Define DMEM_SUBWORD_EN to allow byte/half accesses.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic clock,
  input  logic reset,
  data_mem_responder_if.slave bus
);

  localparam int IDXW = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;
  localparam logic [CNT_W-1:0] LAT = CNT_W'(LATENCY);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t state, nextState;
  logic [CNT_W-1:0] waitCnt;

  logic        writeQ;
  logic [31:0] addrQ;
  logic [31:0] wdataQ;
  logic [1:0]  sizeQ;

  logic [31:0] mem [DEPTH_WORDS];

  logic [32:0]     offset;
  logic [IDXW-1:0] wordIdx;
  logic [31:0]     curWord;
  logic [31:0]     newWord;
  logic [31:0]     loadData;
  logic badSize, misalign, outRange;
  logic accessErr, accept;

  assign bus.req_ready = (state == IDLE) && !reset;
  assign bus.rsp_valid = (state == RESP);
  assign accept = bus.req_valid && bus.req_ready;

  // a borrow lands in bit 32, so below-base also fails the span test
  assign offset   = {1'b0, addrQ} - {1'b0, BASE_ADDR};
  assign wordIdx  = offset[IDXW+1:2];
  assign curWord  = mem[wordIdx];
  assign outRange = (offset >= SPAN);

  assign misalign =
    ((sizeQ == SZ_HALF) && addrQ[0]) ||
    ((sizeQ == SZ_WORD) && (addrQ[1:0] != 2'b00));

  assign accessErr = badSize || misalign || outRange;

`ifdef DMEM_SUBWORD_EN
  logic unsQ;

  assign badSize = (sizeQ == 2'b11);

  always_ff @(posedge clock) begin
    if (accept) unsQ <= bus.req_unsigned;
  end

  dmem_lane_align uLane (
    .word       (curWord),
    .wdata      (wdataQ),
    .size       (sizeQ),
    .offs       (addrQ[1:0]),
    .isUnsigned (unsQ),
    .newWord    (newWord),
    .loadData   (loadData)
  );
`else
  logic unusedUns;

  assign badSize   = (sizeQ != SZ_WORD);
  assign newWord   = wdataQ;
  assign loadData  = curWord;
  assign unusedUns = bus.req_unsigned;
`endif

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE: begin
        if (accept)
          nextState = (LATENCY > 0) ? WAIT : ACCESS;
      end
      WAIT: begin
        if (waitCnt == ONE) nextState = ACCESS;
      end
      ACCESS: nextState = RESP;
      RESP: begin
        if (bus.rsp_ready) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      waitCnt       <= '0;
      bus.rsp_rdata <= '0;
      bus.rsp_error <= 1'b0;
    end else begin
      state <= nextState;
      if (state == WAIT) waitCnt <= waitCnt - ONE;
      if (accept) begin
        waitCnt <= LAT;
        writeQ  <= bus.req_write;
        addrQ   <= bus.req_addr;
        wdataQ  <= bus.req_wdata;
        sizeQ   <= bus.req_size;
      end
      if (state == ACCESS) begin
        bus.rsp_error <= accessErr;
        bus.rsp_rdata <= (accessErr || writeQ) ? 32'h0 : loadData;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && state == ACCESS && writeQ && !accessErr)
      mem[wordIdx] <= newWord;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed scenarios plus
// random traffic against a byte-level reference memory.
module tb_data_mem_responder;
  import dmem_pkg::*;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  data_mem_responder_if busA ();
  data_mem_responder_if busB ();

  logic        sel, reqValid, reqWrite, reqUns, rspReady;
  logic [31:0] reqAddr, reqWdata;
  logic [1:0]  reqSize;
  logic        rdy, rvalid, rerr;
  logic [31:0] rdata;

  assign busA.req_valid    = reqValid && !sel;
  assign busB.req_valid    = reqValid && sel;
  assign busA.req_write    = reqWrite;
  assign busB.req_write    = reqWrite;
  assign busA.req_addr     = reqAddr;
  assign busB.req_addr     = reqAddr;
  assign busA.req_wdata    = reqWdata;
  assign busB.req_wdata    = reqWdata;
  assign busA.req_size     = reqSize;
  assign busB.req_size     = reqSize;
  assign busA.req_unsigned = reqUns;
  assign busB.req_unsigned = reqUns;
  assign busA.rsp_ready    = rspReady;
  assign busB.rsp_ready    = rspReady;

  assign rdy    = sel ? busB.req_ready : busA.req_ready;
  assign rvalid = sel ? busB.rsp_valid : busA.rsp_valid;
  assign rdata  = sel ? busB.rsp_rdata : busA.rsp_rdata;
  assign rerr   = sel ? busB.rsp_error : busA.rsp_error;

  data_mem_responder dut (
    .clock (clock), .reset (reset), .bus (busA)
  );

  data_mem_responder #(
    .DEPTH_WORDS (16), .LATENCY (0), .BASE_ADDR (32'h1000)
  ) dut0 (
    .clock (clock), .reset (reset), .bus (busB)
  );

  logic [31:0] luWord, luWdata, luNew, luLoad;
  logic [1:0]  luSize, luOffs;
  logic        luUns;

  dmem_lane_align uLane (
    .word (luWord), .wdata (luWdata), .size (luSize),
    .offs (luOffs), .isUnsigned (luUns),
    .newWord (luNew), .loadData (luLoad)
  );

  int nCmp = 0;
  int nBad = 0;
  logic [31:0] refMem [int];

  function automatic void refLane(
    input logic [31:0] word, input logic [31:0] wdata,
    input logic [1:0] size, input logic [1:0] offs, input bit uns,
    output logic [31:0] nw, output logic [31:0] ld);
    int nb, k;
    logic [31:0] mask;
    nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    k  = int'(offs);
    nw = word;
    for (int b = 0; b < nb; b++) nw[8*(k+b) +: 8] = wdata[8*b +: 8];
    ld = word >> (8 * k);
    if (nb < 4) begin
      mask = (32'd1 << (8 * nb)) - 32'd1;
      ld = ld & mask;
      if (!uns && ld[8*nb-1]) ld = ld | ~mask;
    end
  endfunction

  function automatic void refAccess(
    input bit s, input bit wr, input logic [31:0] addr,
    input logic [31:0] wdata, input logic [1:0] size, input bit uns,
    output logic [31:0] rd, output bit er);
    longint base, span, a;
    int nb, key;
    logic [31:0] nw, ld;
    base = s ? 64'h1000 : 64'h0;
    span = s ? 64 : 1024;
    a = {32'd0, addr};
    nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    er = (size == 2'd3) || (a < base) || (a - base >= span) || (a % nb != 0);
`ifndef DMEM_SUBWORD_EN
    if (size != 2'd2) er = 1'b1;
`endif
    rd = 32'h0;
    if (!er) begin
      key = (s ? 4096 : 0) + int'((a - base) / 4);
      refLane(refMem[key], wdata, size, addr[1:0], uns, nw, ld);
      if (wr) refMem[key] = nw;
      else rd = ld;
    end
  endfunction

  task automatic txn(
    input bit s, input bit wr, input logic [31:0] addr,
    input logic [31:0] wdata, input logic [1:0] size, input bit uns,
    output logic [31:0] rd, output bit er, output int lat);
    int t;
    @(negedge clock);
    sel = s; reqWrite = wr; reqAddr = addr; reqWdata = wdata;
    reqSize = size; reqUns = uns; rspReady = 1'b1; reqValid = 1'b1;
    #1;
    t = 0;
    while (!rdy && t < 20) begin @(negedge clock); #1; t++; end
    @(negedge clock);
    reqValid = 1'b0;
    #1;
    lat = 1;
    while (!rvalid && lat < 40) begin @(negedge clock); #1; lat++; end
    rd = rdata;
    er = rerr;
  endtask

  task automatic runOp(
    input bit s, input bit wr, input logic [31:0] addr,
    input logic [31:0] wdata, input logic [1:0] size, input bit uns,
    output logic [31:0] rd, output logic [31:0] expRd,
    output bit er, output bit expEr, output int lat);
    refAccess(s, wr, addr, wdata, size, uns, expRd, expEr);
    txn(s, wr, addr, wdata, size, uns, rd, er, lat);
  endtask

  task automatic test_reset();
    reset = 1'b1; sel = 1'b0; reqValid = 1'b0; rspReady = 1'b1;
    reqWrite = 1'b0; reqAddr = '0; reqWdata = '0; reqSize = SZ_WORD; reqUns = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    nCmp++; if (busA.rsp_valid !== 1'b0) begin nBad++; $display("FAIL rst_valid got %b want 0", busA.rsp_valid); end
    nCmp++; if (busA.rsp_rdata !== 32'h0) begin nBad++; $display("FAIL rst_rdata got %h want 0", busA.rsp_rdata); end
    nCmp++; if (busA.rsp_error !== 1'b0) begin nBad++; $display("FAIL rst_error got %b want 0", busA.rsp_error); end
    nCmp++; if (busA.req_ready !== 1'b0) begin nBad++; $display("FAIL rst_ready_in got %b want 0", busA.req_ready); end
    reset = 1'b0;
    #1;
    nCmp++; if (busA.req_ready !== 1'b1) begin nBad++; $display("FAIL rst_ready_out got %b want 1", busA.req_ready); end
    nCmp++; if (busB.req_ready !== 1'b1) begin nBad++; $display("FAIL rst_ready_b got %b want 1", busB.req_ready); end
  endtask

  task automatic test_word();
    logic [31:0] rd, ex; bit er, ee; int lat;
    runOp(0, 1, 32'h10, 32'hDEADBEEF, SZ_WORD, 0, rd, ex, er, ee, lat);
    nCmp++; if (er !== 1'b0) begin nBad++; $display("FAIL sw_err got %b want 0", er); end
    nCmp++; if (lat != 4) begin nBad++; $display("FAIL sw_lat got %0d want 4", lat); end
    runOp(0, 0, 32'h10, 32'h0, SZ_WORD, 0, rd, ex, er, ee, lat);
    nCmp++; if (rd !== 32'hDEADBEEF) begin nBad++; $display("FAIL lw_rdata got %h want deadbeef", rd); end
    nCmp++; if (er !== 1'b0) begin nBad++; $display("FAIL lw_err got %b want 0", er); end
    nCmp++; if (lat != 4) begin nBad++; $display("FAIL lw_lat got %0d want 4", lat); end
  endtask

  task automatic test_subword();
    logic [31:0] rd, ex; bit er, ee; int lat;
    bit          wrs[5] = '{1, 0, 0, 0, 0};
    logic [31:0] ads[5] = '{32'h11, 32'h10, 32'h11, 32'h11, 32'h12};
    logic [1:0]  szs[5] = '{SZ_BYTE, SZ_WORD, SZ_BYTE, SZ_BYTE, SZ_HALF};
    bit          uns[5] = '{0, 0, 0, 1, 0};
`ifdef DMEM_SUBWORD_EN
    logic [31:0] lit[5] = '{32'h0, 32'hDEADAAEF, 32'hFFFFFFAA, 32'h000000AA, 32'hFFFFDEAD};
`else
    logic [31:0] lit[5] = '{32'h0, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0};
`endif
    for (int i = 0; i < 5; i++) begin
      runOp(0, wrs[i], ads[i], 32'h000000AA, szs[i], uns[i], rd, ex, er, ee, lat);
      nCmp++; if (rd !== lit[i]) begin nBad++; $display("FAIL sub_rdata[%0d] got %h want %h", i, rd, lit[i]); end
      nCmp++; if (er !== ee) begin nBad++; $display("FAIL sub_err[%0d] got %b want %b", i, er, ee); end
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd, ex; bit er, ee; int lat;
    bit          wrs[5] = '{0, 1, 1, 1, 0};
    logic [31:0] ads[5] = '{32'h12, 32'h400, 32'h10, 32'h3FC, 32'h10};
    logic [1:0]  szs[5] = '{SZ_WORD, SZ_WORD, 2'b11, SZ_WORD, SZ_WORD};
    bit          eLit[5] = '{1, 1, 1, 0, 0};
    for (int i = 0; i < 5; i++) begin
      runOp(0, wrs[i], ads[i], 32'h55AA55AA, szs[i], 0, rd, ex, er, ee, lat);
      nCmp++; if (er !== eLit[i]) begin nBad++; $display("FAIL err_flag[%0d] got %b want %b", i, er, eLit[i]); end
      nCmp++; if (rd !== ex) begin nBad++; $display("FAIL err_rdata[%0d] got %h want %h", i, rd, ex); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd, ex, held; bit er, ee; int t, lat;
    refAccess(0, 0, 32'h10, 32'h0, SZ_WORD, 0, ex, ee);
    @(negedge clock);
    sel = 1'b0; reqWrite = 1'b0; reqAddr = 32'h10; reqSize = SZ_WORD;
    rspReady = 1'b0; reqValid = 1'b1;
    #1;
    t = 0;
    while (!rdy && t < 20) begin @(negedge clock); #1; t++; end
    @(negedge clock);
    reqValid = 1'b0;
    #1;
    t = 0;
    while (!rvalid && t < 40) begin @(negedge clock); #1; t++; end
    held = rdata;
    nCmp++; if (held !== ex) begin nBad++; $display("FAIL bp_rdata got %h want %h", held, ex); end
    reqWrite = 1'b1; reqWdata = 32'h0BADF00D; reqValid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock); #1;
      nCmp++; if (rvalid !== 1'b1) begin nBad++; $display("FAIL bp_valid[%0d] got %b want 1", i, rvalid); end
      nCmp++; if (rdata !== held) begin nBad++; $display("FAIL bp_stable[%0d] got %h want %h", i, rdata, held); end
      nCmp++; if (rdy !== 1'b0) begin nBad++; $display("FAIL bp_ready[%0d] got %b want 0", i, rdy); end
    end
    reqValid = 1'b0; reqWrite = 1'b0; rspReady = 1'b1;
    @(negedge clock); #1;
    nCmp++; if (rdy !== 1'b1) begin nBad++; $display("FAIL bp_idle_ready got %b want 1", rdy); end
    nCmp++; if (rvalid !== 1'b0) begin nBad++; $display("FAIL bp_idle_valid got %b want 0", rvalid); end
    runOp(0, 0, 32'h10, 32'h0, SZ_WORD, 0, rd, ex, er, ee, lat);
    nCmp++; if (rd !== ex) begin nBad++; $display("FAIL bp_after got %h want %h", rd, ex); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, ex; bit er, ee; int t, lat;
    runOp(0, 1, 32'h20, 32'hCAFEF00D, SZ_WORD, 0, rd, ex, er, ee, lat);
    @(negedge clock);
    sel = 1'b0; reqWrite = 1'b1; reqAddr = 32'h20; reqWdata = 32'h12345678;
    reqSize = SZ_WORD; rspReady = 1'b1; reqValid = 1'b1;
    #1;
    t = 0;
    while (!rdy && t < 20) begin @(negedge clock); #1; t++; end
    @(negedge clock);
    reqValid = 1'b0; reset = 1'b1;
    @(negedge clock); #1;
    nCmp++; if (rvalid !== 1'b0) begin nBad++; $display("FAIL rmid_valid got %b want 0", rvalid); end
    nCmp++; if (rdata !== 32'h0) begin nBad++; $display("FAIL rmid_rdata got %h want 0", rdata); end
    nCmp++; if (rerr !== 1'b0) begin nBad++; $display("FAIL rmid_error got %b want 0", rerr); end
    reset = 1'b0;
    #1;
    nCmp++; if (rdy !== 1'b1) begin nBad++; $display("FAIL rmid_ready got %b want 1", rdy); end
    runOp(0, 0, 32'h20, 32'h0, SZ_WORD, 0, rd, ex, er, ee, lat);
    nCmp++; if (rd !== 32'hCAFEF00D) begin nBad++; $display("FAIL rmid_keep got %h want cafef00d", rd); end
    refAccess(0, 0, 32'h10, 32'h0, SZ_WORD, 0, ex, ee);
    @(negedge clock);
    reqWrite = 1'b0; reqAddr = 32'h10; rspReady = 1'b0; reqValid = 1'b1;
    #1;
    t = 0;
    while (!rdy && t < 20) begin @(negedge clock); #1; t++; end
    @(negedge clock);
    reqValid = 1'b0;
    #1;
    t = 0;
    while (!rvalid && t < 40) begin @(negedge clock); #1; t++; end
    nCmp++; if (rdata !== ex) begin nBad++; $display("FAIL rresp_pre got %h want %h", rdata, ex); end
    reset = 1'b1;
    @(negedge clock); #1;
    nCmp++; if (rvalid !== 1'b0) begin nBad++; $display("FAIL rresp_valid got %b want 0", rvalid); end
    nCmp++; if (rdata !== 32'h0) begin nBad++; $display("FAIL rresp_rdata got %h want 0", rdata); end
    reset = 1'b0; rspReady = 1'b1;
  endtask

  task automatic test_random();
    logic [31:0] rd, ex, addr; bit er, ee; int r, lat;
    for (int i = 0; i < 16; i++) begin
      runOp(0, 1, 32'(i * 4), $urandom, SZ_WORD, 0, rd, ex, er, ee, lat);
      nCmp++; if (er !== 1'b0) begin nBad++; $display("FAIL init_err[%0d] got %b want 0", i, er); end
    end
    for (int n = 0; n < 80; n++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0) addr = 32'h400 + $urandom_range(0, 255);
      else if (r == 1) addr = 32'hFFFF_FF00 + $urandom_range(0, 255);
      else addr = 32'($urandom_range(0, 63));
      runOp(0, 1'($urandom_range(0, 1)), addr, $urandom,
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            rd, ex, er, ee, lat);
      nCmp++; if (rd !== ex) begin nBad++; $display("FAIL rnd_rdata[%0d] addr %h got %h want %h", n, addr, rd, ex); end
      nCmp++; if (er !== ee) begin nBad++; $display("FAIL rnd_err[%0d] addr %h got %b want %b", n, addr, er, ee); end
      nCmp++; if (lat != 4) begin nBad++; $display("FAIL rnd_lat[%0d] got %0d want 4", n, lat); end
    end
  endtask

  task automatic test_latency0();
    logic [31:0] rd, ex; bit er, ee; int lat;
    bit          wrs[8] = '{1, 0, 1, 0, 0, 0, 1, 0};
    logic [31:0] ads[8] = '{32'h1000, 32'h1000, 32'h103C, 32'h103C,
                            32'h1040, 32'h0FFC, 32'h1001, 32'h1000};
    logic [31:0] wds[8] = '{32'h11223344, 32'h0, 32'hA5A5A5A5, 32'h0,
                            32'h0, 32'h0, 32'h77, 32'h0};
    logic [1:0]  szs[8] = '{SZ_WORD, SZ_WORD, SZ_WORD, SZ_WORD,
                            SZ_WORD, SZ_WORD, SZ_BYTE, SZ_WORD};
    for (int i = 0; i < 8; i++) begin
      runOp(1, wrs[i], ads[i], wds[i], szs[i], 0, rd, ex, er, ee, lat);
      nCmp++; if (rd !== ex) begin nBad++; $display("FAIL l0_rdata[%0d] got %h want %h", i, rd, ex); end
      nCmp++; if (er !== ee) begin nBad++; $display("FAIL l0_err[%0d] got %b want %b", i, er, ee); end
      nCmp++; if (lat != 2) begin nBad++; $display("FAIL l0_lat[%0d] got %0d want 2", i, lat); end
    end
  endtask

  task automatic test_lane_unit();
    logic [31:0] nw, ld;
    for (int i = 0; i < 40; i++) begin
      luWord  = $urandom;
      luWdata = $urandom;
      luSize  = 2'($urandom_range(0, 2));
      luOffs  = 2'($urandom_range(0, 3));
      if (luSize == SZ_HALF) luOffs[0] = 1'b0;
      if (luSize == SZ_WORD) luOffs = 2'b00;
      luUns = 1'($urandom_range(0, 1));
      #1;
      refLane(luWord, luWdata, luSize, luOffs, luUns, nw, ld);
      nCmp++; if (luNew !== nw) begin nBad++; $display("FAIL lane_merge[%0d] got %h want %h", i, luNew, nw); end
      nCmp++; if (luLoad !== ld) begin nBad++; $display("FAIL lane_load[%0d] got %h want %h", i, luLoad, ld); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_word();
    test_subword();
    test_errors();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_latency0();
    test_lane_unit();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
